// File: rtl/reg_file_ctrl_if.sv
// Command/response handshake bundle between a requester and reg_file_ctrl.
// Latency: wires only; no state lives in the interface.
// Backpressure: cmd_valid/cmd_ready on the command side and rsp_valid/rsp_ready on the response side.
//   master : drives cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready
//   slave  : drives cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_is_write
interface reg_file_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  rsp_is_write;

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_is_write
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_is_write
    );
endinterface

// File: rtl/reg_file_ctrl.sv
// Turns one command at a time into a single register-file strobe and one response.
// Latency: write response 2 cycles after the accept cycle, read response 3 (prompt responder), read timeout after TIMEOUT wait cycles.
// Backpressure: cmd_ready only in IDLE; the response is held until rsp_ready, so one command is outstanding at most.
//   ports: clk, reset (async, active high), bus (slave side of reg_file_ctrl_if),
//          WrEN/RdEN/address/WrData to the register file, RdData/RdData_Valid back from it.
module reg_file_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int TIMEOUT    = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    reg_file_ctrl_if.slave        bus,
    output logic                  WrEN,
    output logic                  RdEN,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] WrData,
    input  logic [DATA_WIDTH-1:0] RdData,
    input  logic                  RdData_Valid
);
    localparam int CW = $clog2(TIMEOUT + 1);
    // WAIT ends on the cycle whose counter value is TIMEOUT-1, giving exactly TIMEOUT wait cycles.
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        WAIT,
        RESP
    } state_t;

    state_t                state;
    logic                  op_write;
    logic [CW-1:0]         to_cnt;
    logic                  rsp_valid_q;
    logic                  rsp_err_q;
    logic                  rsp_is_write_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;

    // Gated by reset directly so that ready drops the moment reset rises,
    // and is already high in the first cycle after reset falls.
    assign bus.cmd_ready    = (state == IDLE) && !reset;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_err      = rsp_err_q;
    assign bus.rsp_is_write = rsp_is_write_q;
    assign bus.rsp_rdata    = rsp_rdata_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            op_write       <= 1'b0;
            to_cnt         <= '0;
            WrEN           <= 1'b0;
            RdEN           <= 1'b0;
            address        <= '0;
            WrData         <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_err_q      <= 1'b0;
            rsp_is_write_q <= 1'b0;
            rsp_rdata_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // cmd_ready is 1 here whenever reset is low, so valid alone accepts.
                    if (bus.cmd_valid) begin
                        address  <= bus.cmd_addr;
                        op_write <= bus.cmd_write;
                        if (bus.cmd_write) begin
                            WrData <= bus.cmd_wdata;
                            WrEN   <= 1'b1;
                            state  <= WRITE;
                        end else begin
                            RdEN   <= 1'b1;
                            state  <= READ;
                        end
                    end
                end
                WRITE: begin
                    WrEN           <= 1'b0;
                    rsp_valid_q    <= 1'b1;
                    rsp_err_q      <= 1'b0;
                    rsp_rdata_q    <= '0;
                    rsp_is_write_q <= op_write;
                    state          <= RESP;
                end
                READ: begin
                    RdEN   <= 1'b0;
                    to_cnt <= '0;
                    state  <= WAIT;
                end
                WAIT: begin
                    // Valid data takes priority over an expiring timeout.
                    if (RdData_Valid) begin
                        rsp_valid_q    <= 1'b1;
                        rsp_err_q      <= 1'b0;
                        rsp_rdata_q    <= RdData;
                        rsp_is_write_q <= op_write;
                        state          <= RESP;
                    end else if (to_cnt >= TO_LAST) begin
                        rsp_valid_q    <= 1'b1;
                        rsp_err_q      <= 1'b1;
                        rsp_rdata_q    <= '0;
                        rsp_is_write_q <= op_write;
                        state          <= RESP;
                    end else if (to_cnt != CNT_MAX) begin
                        to_cnt <= to_cnt + CW'(1);
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q    <= 1'b0;
                        rsp_err_q      <= 1'b0;
                        rsp_rdata_q    <= '0;
                        rsp_is_write_q <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: begin
                    WrEN  <= 1'b0;
                    RdEN  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_reg_file_ctrl.sv
// Directed bench for reg_file_ctrl with a small register-file model and a
// response scoreboard used during the back-to-back random phase.
module tb_reg_file_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        WrEN, RdEN;
    logic [3:0]  address;
    logic [31:0] WrData;
    logic [31:0] RdData;
    logic        RdData_Valid;

    reg_file_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) bus ();

    reg_file_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .TIMEOUT(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .WrEN         (WrEN),
        .RdEN         (RdEN),
        .address      (address),
        .WrData       (WrData),
        .RdData       (RdData),
        .RdData_Valid (RdData_Valid)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Register-file model: data one cycle after the RdEN cycle.
    logic [31:0] rf_mem [16];
    logic        rf_en = 1'b1;
    logic        rd_vld = 1'b0;
    logic [31:0] rd_dat = '0;
    logic        man_vld = 1'b0;
    logic [31:0] man_dat = '0;

    always @(posedge clk) begin
        if (WrEN) rf_mem[address] <= WrData;
        rd_vld <= RdEN;
        rd_dat <= rf_mem[address];
    end

    assign RdData_Valid = rf_en ? rd_vld : man_vld;
    assign RdData       = rf_en ? rd_dat : man_dat;

    // Strobe and response monitors.
    int wr_cnt = 0, rd_cnt = 0, both_cnt = 0, rsp_cnt = 0;
    logic        rnd_on = 1'b0;
    logic [31:0] exp_mem [16];
    logic [32:0] exp_q [$];

    always @(posedge clk) begin
        if (!reset) begin
            if (WrEN) wr_cnt++;
            if (RdEN) rd_cnt++;
            if (WrEN && RdEN) both_cnt++;
            if (rnd_on && bus.cmd_valid && bus.cmd_ready) begin
                if (bus.cmd_write) begin
                    exp_mem[bus.cmd_addr] = bus.cmd_wdata;
                    exp_q.push_back({1'b1, 32'h0});
                end else begin
                    exp_q.push_back({1'b0, exp_mem[bus.cmd_addr]});
                end
            end
            if (rnd_on && bus.rsp_valid && bus.rsp_ready) begin
                logic [32:0] e;
                rsp_cnt++;
                if (exp_q.size() == 0) begin
                    check("rnd_unexpected_rsp", 64'(exp_q.size()), 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("rnd_is_write", bus.rsp_is_write, e[32]);
                    check("rnd_rdata", bus.rsp_rdata, e[31:0]);
                    check("rnd_err", bus.rsp_err, 1'b0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int wr0, rd0;
        logic [31:0] hold_rdata;

        for (int i = 0; i < 16; i++) rf_mem[i] = 32'h1000_0000 + i;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.rsp_ready = 1'b0;

        // Reset state
        tick(); tick();
        check("rst_cmd_ready", bus.cmd_ready, 1'b0);
        check("rst_rsp_valid", bus.rsp_valid, 1'b0);
        check("rst_strobes", {WrEN, RdEN}, 2'b00);
        check("rst_address", address, 4'd0);
        reset = 1'b0;
        #1;
        check("post_rst_cmd_ready", bus.cmd_ready, 1'b1);

        // Write addr 5 = DEADBEEF
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 4'd5; bus.cmd_wdata = 32'hDEAD_BEEF;
        tick();
        bus.cmd_valid = 1'b0;
        check("wr_wren", WrEN, 1'b1);
        check("wr_rden", RdEN, 1'b0);
        check("wr_address", address, 4'd5);
        check("wr_wrdata", WrData, 32'hDEAD_BEEF);
        check("wr_rsp_early", bus.rsp_valid, 1'b0);
        check("wr_cmd_ready_busy", bus.cmd_ready, 1'b0);
        tick();
        check("wr_wren_one_cycle", WrEN, 1'b0);
        check("wr_rsp_valid", bus.rsp_valid, 1'b1);
        check("wr_rsp_err", bus.rsp_err, 1'b0);
        check("wr_rsp_is_write", bus.rsp_is_write, 1'b1);
        check("wr_rsp_rdata", bus.rsp_rdata, 32'h0);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        check("wr_rsp_done", bus.rsp_valid, 1'b0);
        check("wr_cmd_ready_back", bus.cmd_ready, 1'b1);
        check("wr_address_hold", address, 4'd5);

        // Read addr 5, then hold off rsp_ready for 5 cycles
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 4'd5;
        tick();
        bus.cmd_valid = 1'b0;
        check("rd_rden", RdEN, 1'b1);
        check("rd_wren", WrEN, 1'b0);
        tick();
        check("rd_rden_one_cycle", RdEN, 1'b0);
        check("rd_rsp_early", bus.rsp_valid, 1'b0);
        tick();
        check("rd_rsp_valid", bus.rsp_valid, 1'b1);
        check("rd_rsp_rdata", bus.rsp_rdata, 32'hDEAD_BEEF);
        check("rd_rsp_err", bus.rsp_err, 1'b0);
        check("rd_rsp_is_write", bus.rsp_is_write, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_rsp_valid", bus.rsp_valid, 1'b1);
            check("stall_rsp_rdata", bus.rsp_rdata, 32'hDEAD_BEEF);
            check("stall_cmd_ready", bus.cmd_ready, 1'b0);
            check("stall_strobes", {WrEN, RdEN}, 2'b00);
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        check("stall_release_ready", bus.cmd_ready, 1'b1);
        check("stall_release_valid", bus.rsp_valid, 1'b0);

        // Read timeout: no read data for 8 WAIT cycles
        rf_en = 1'b0;
        bus.cmd_valid = 1'b1; bus.cmd_addr = 4'd3;
        tick();
        bus.cmd_valid = 1'b0;
        check("to_rden", RdEN, 1'b1);
        tick();
        for (int i = 0; i < 7; i++) begin
            tick();
            check("to_waiting", {bus.rsp_valid, WrEN, RdEN}, 3'b000);
        end
        tick();
        check("to_rsp_valid", bus.rsp_valid, 1'b1);
        check("to_rsp_err", bus.rsp_err, 1'b1);
        check("to_rsp_rdata", bus.rsp_rdata, 32'h0);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;

        // Data arriving on the final timeout cycle wins
        bus.cmd_valid = 1'b1; bus.cmd_addr = 4'd7;
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        for (int i = 0; i < 7; i++) tick();
        check("late_not_yet", bus.rsp_valid, 1'b0);
        man_vld = 1'b1; man_dat = 32'h1234_5678;
        tick();
        man_vld = 1'b0;
        check("late_rsp_valid", bus.rsp_valid, 1'b1);
        check("late_rsp_err", bus.rsp_err, 1'b0);
        check("late_rsp_rdata", bus.rsp_rdata, 32'h1234_5678);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;

        // Reset pulsed during WAIT
        bus.cmd_valid = 1'b1; bus.cmd_addr = 4'd4;
        tick();
        bus.cmd_valid = 1'b0;
        tick(); tick();
        #2;
        reset = 1'b1;
        #1;
        check("midrst_outputs", {bus.cmd_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_is_write, WrEN, RdEN}, 6'd0);
        check("midrst_address", address, 4'd0);
        tick();
        reset = 1'b0;
        rf_en = 1'b1;
        #1;
        check("midrst_ready_after", bus.cmd_ready, 1'b1);
        n = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.rsp_valid) n++;
        end
        check("midrst_no_rsp", 64'(n), 64'd0);
        bus.cmd_valid = 1'b1; bus.cmd_addr = 4'd2;
        tick();
        bus.cmd_valid = 1'b0;
        check("rd2_rden", RdEN, 1'b1);
        tick(); tick();
        check("rd2_rsp_valid", bus.rsp_valid, 1'b1);
        check("rd2_rsp_rdata", bus.rsp_rdata, 32'h1000_0002);
        check("rd2_rsp_err", bus.rsp_err, 1'b0);
        bus.rsp_ready = 1'b1;
        tick();

        // Ten back-to-back random commands
        for (int i = 0; i < 16; i++) exp_mem[i] = rf_mem[i];
        wr0 = wr_cnt; rd0 = rd_cnt; rsp_cnt = 0;
        rnd_on = 1'b1;
        bus.cmd_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            bus.cmd_write = 1'($urandom_range(0, 1));
            bus.cmd_addr  = 4'($urandom_range(0, 15));
            bus.cmd_wdata = $urandom;
            n = 0;
            while (!bus.cmd_ready && n < 40) begin
                tick();
                n++;
            end
            if (n >= 40) check("rnd_accept_timeout", 64'(n), 64'd0);
            tick();
        end
        bus.cmd_valid = 1'b0;
        n = 0;
        while (rsp_cnt < 10 && n < 60) begin
            tick();
            n++;
        end
        tick(); tick();
        check("rnd_rsp_count", 64'(rsp_cnt), 64'd10);
        check("rnd_strobe_count", 64'((wr_cnt - wr0) + (rd_cnt - rd0)), 64'd10);
        check("rnd_queue_empty", 64'(exp_q.size()), 64'd0);
        check("never_both_strobes", 64'(both_cnt), 64'd0);
        rnd_on = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/reg_file_ctrl.md
REG_FILE_CTRL -- requirements
Module: reg_file_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the data width of command, response and register-file buses.
REQ-002 Parameter ADDR_WIDTH, default 4, SHALL set the register address width.
REQ-003 Parameter TIMEOUT, default 8, SHALL set the number of cycles to wait for read data before flagging an error; legal range >= 1.
REQ-004 clk  in  1  single clock; all state SHALL change on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 cmd_valid  in  1  command request.
REQ-007 cmd_ready  out  1  block can accept a command.
REQ-008 cmd_write  in  1  1 = write, 0 = read.
REQ-009 cmd_addr  in  ADDR_WIDTH  target register.
REQ-010 cmd_wdata  in  DATA_WIDTH  write data.
REQ-011 rsp_valid  out  1  response available.
REQ-012 rsp_ready  in  1  consumer accepts the response.
REQ-013 rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and errors.
REQ-014 rsp_err  out  1  read timed out.
REQ-015 rsp_is_write  out  1  response belongs to a write command.
REQ-016 WrEN, RdEN  out  1 each  register-file write and read strobes.
REQ-017 address  out  ADDR_WIDTH  register-file address.
REQ-018 WrData  out  DATA_WIDTH  register-file write data.
REQ-019 RdData  in  DATA_WIDTH  register-file read data.
REQ-020 RdData_Valid  in  1  register-file read data valid; the data arrives one cycle after the RdEN cycle.

Function
REQ-021 The FSM SHALL have the states IDLE, WRITE, READ, WAIT and RESP.
REQ-022 cmd_ready SHALL be 1 only in IDLE with reset low; a command is accepted on a rising edge where cmd_valid and cmd_ready are both 1.
REQ-023 On acceptance the block SHALL latch cmd_addr into address, cmd_wdata into WrData (write commands only) and cmd_write, then enter WRITE (cmd_write=1) or READ (cmd_write=0).
REQ-024 address and WrData SHALL hold their latched values until the next acceptance.
REQ-025 WRITE: WrEN=1 and RdEN=0 for exactly one cycle; the next state SHALL be RESP with rsp_err=0, rsp_rdata=0 and rsp_is_write=1.
REQ-026 READ: RdEN=1 and WrEN=0 for exactly one cycle; the next state SHALL be WAIT with the timeout counter cleared.
REQ-027 WAIT: both strobes SHALL be 0; when RdData_Valid=1 the block SHALL capture RdData into rsp_rdata, set rsp_err=0 and enter RESP.
REQ-028 WAIT: after TIMEOUT cycles with RdData_Valid=0 the block SHALL enter RESP with rsp_err=1 and rsp_rdata=0.
REQ-029 If RdData_Valid is 1 on the final timeout cycle, the valid data SHALL win (rsp_err=0).
REQ-030 The timeout counter SHALL be $clog2(TIMEOUT+1) bits wide and SHALL saturate, never wrap.
REQ-031 RESP: rsp_valid=1, with rsp_rdata, rsp_err and rsp_is_write held stable until rsp_ready=1; the edge with rsp_valid and rsp_ready both 1 SHALL return the FSM to IDLE and deassert rsp_valid.
REQ-032 RdData_Valid SHALL be ignored outside WAIT.
REQ-033 WrEN and RdEN SHALL never be 1 in the same cycle.
REQ-034 Each accepted command SHALL produce exactly one strobe cycle and exactly one response.
REQ-035 Latency from the accept edge: write response valid 2 cycles later; read response valid 3 cycles later with a prompt responder.
REQ-036 Throughput: at most one command outstanding; a new command can be accepted no earlier than the cycle after the response handshake.

Reset
REQ-037 While reset=1, independent of clk: state=IDLE and cmd_ready, rsp_valid, rsp_err, rsp_is_write, WrEN and RdEN=0; rsp_rdata, address, WrData and the timeout counter=0.
REQ-038 Reset asserted mid-operation (any state) SHALL drop the strobes immediately and discard the pending response; no response is issued for that command after release.
REQ-039 The first cycle after reset falls, cmd_ready SHALL be 1.

Verification
REQ-040 Write addr 5, data 0xDEADBEEF -> WrEN=1 for one cycle with address=5 and WrData=0xDEADBEEF; rsp_valid 2 cycles after accept with rsp_err=0, rsp_is_write=1, rsp_rdata=0.
REQ-041 Then read addr 5 against a register-file model -> RdEN=1 for one cycle; rsp_valid 3 cycles after accept with rsp_rdata=0xDEADBEEF and rsp_err=0.
REQ-042 Read with RdData_Valid tied 0, TIMEOUT=8 -> no further strobes; after 8 WAIT cycles rsp_valid=1, rsp_err=1, rsp_rdata=0.
REQ-043 rsp_ready held 0 for 5 cycles in RESP -> rsp_* stable, cmd_ready=0, no strobes; on rsp_ready=1, cmd_ready=1 the next cycle.
REQ-044 Reset pulsed during WAIT -> all outputs 0 asynchronously, no response after release, and a following read of addr 2 completes normally.
REQ-045 Ten back-to-back random commands with cmd_valid held 1 -> exactly ten strobes and ten responses in order, and WrEN & RdEN never both 1.
